// File: rtl/truth_sweep_checker.sv
// Sweeps all 2**N minterms of two latched truth tables, counting mismatches and
// recording the first one. Define TRUTH_SWEEP_STOP_EN to end the sweep at the first mismatch.
module truth_sweep_checker #(
  parameter  int N = 4,
  localparam int M = 1 << N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [M-1:0] tt_a,
  input  logic [M-1:0] tt_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] vec,
  output logic         s_a,
  output logic         s_b,
  output logic [N:0]   mism_cnt,
  output logic [N-1:0] first_idx,
  output logic         first_vld,
  output logic         equal
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  localparam logic [N-1:0] LAST = N'(M-1);

  state_e       state_q;
  logic [N-1:0] idx_q;
  logic [M-1:0] tta_q, ttb_q;
  logic [N:0]   mism_q;
  logic [N-1:0] fidx_q;
  logic         fvld_q;
  logic         busy_q, done_q, equal_q;

  logic miss_d, stop_d, end_d;

  assign miss_d = tta_q[idx_q] ^ ttb_q[idx_q];
`ifdef TRUTH_SWEEP_STOP_EN
  assign stop_d = miss_d & ~fvld_q;
`else
  assign stop_d = 1'b0;
`endif
  // idx never wraps: the last minterm ends the sweep instead of incrementing
  assign end_d = (idx_q == LAST) | stop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tta_q   <= '0;
      ttb_q   <= '0;
      mism_q  <= '0;
      fidx_q  <= '0;
      fvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            tta_q   <= tt_a;
            ttb_q   <= tt_b;
            idx_q   <= '0;
            mism_q  <= '0;
            fidx_q  <= '0;
            fvld_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            equal_q <= 1'b0;
            state_q <= SWEEP;
          end
        end
        SWEEP: begin
          if (abort) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mism_q  <= '0;
            fidx_q  <= '0;
            fvld_q  <= 1'b0;
            busy_q  <= 1'b0;
            equal_q <= 1'b0;
          end else begin
            if (miss_d) begin
              mism_q <= mism_q + (N+1)'(1);
              if (!fvld_q) begin
                fidx_q <= idx_q;
                fvld_q <= 1'b1;
              end
            end
            if (end_d) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              equal_q <= (mism_q == '0) && !miss_d;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign vec       = idx_q;
  assign s_a       = tta_q[idx_q];
  assign s_b       = ttb_q[idx_q];
  assign mism_cnt  = mism_q;
  assign first_idx = fidx_q;
  assign first_vld = fvld_q;
  assign equal     = equal_q;

endmodule

// File: tb/tb_truth_sweep_checker.sv
// Bench for truth_sweep_checker: prefix-based sweep model on the N=4 instance,
// directed literal checks on N=4, N=1 and N=8 instances.
module tb_truth_sweep_checker;

`ifdef TRUTH_SWEEP_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start4, abort4;
  logic [15:0] tt_a4, tt_b4;
  logic        busy4, done4, s_a4, s_b4, fv4, eq4;
  logic [3:0]  vec4, fidx4;
  logic [4:0]  mism4;

  logic        start1, abort1;
  logic [1:0]  tt_a1, tt_b1;
  logic        busy1, done1, s_a1, s_b1, fv1, eq1;
  logic [0:0]  vec1, fidx1;
  logic [1:0]  mism1;

  logic         start8, abort8;
  logic [255:0] tt_a8, tt_b8;
  logic         busy8, done8, s_a8, s_b8, fv8, eq8;
  logic [7:0]   vec8, fidx8;
  logic [8:0]   mism8;

  truth_sweep_checker #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .tt_a(tt_a4), .tt_b(tt_b4),
    .busy(busy4), .done(done4), .vec(vec4), .s_a(s_a4), .s_b(s_b4), .mism_cnt(mism4),
    .first_idx(fidx4), .first_vld(fv4), .equal(eq4));

  truth_sweep_checker #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .tt_a(tt_a1), .tt_b(tt_b1),
    .busy(busy1), .done(done1), .vec(vec1), .s_a(s_a1), .s_b(s_b1), .mism_cnt(mism1),
    .first_idx(fidx1), .first_vld(fv1), .equal(eq1));

  truth_sweep_checker #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .tt_a(tt_a8), .tt_b(tt_b8),
    .busy(busy8), .done(done8), .vec(vec8), .s_a(s_a8), .s_b(s_b8), .mism_cnt(mism8),
    .first_idx(fidx8), .first_vld(fv8), .equal(eq8));

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else npass++;
  endtask

  // Model: results at any point are functions of the mismatch prefix seen so far.
  function automatic int pc(input logic [15:0] d, input int len);
    int c = 0;
    for (int i = 0; i < len; i++) if (d[i]) c++;
    return c;
  endfunction

  function automatic int fst(input logic [15:0] d, input int len);
    for (int i = 0; i < len; i++) if (d[i]) return i;
    return -1;
  endfunction

  function automatic int mlen(input logic [15:0] d);
    int f;
    f = fst(d, 16);
    if (STOP && f >= 0) return f + 1;
    return 16;
  endfunction

  int          mph;   // 0 idle, 1 sweeping, 2 done
  int          mcnt;
  logic [15:0] msa, msb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mph  <= 0;
      mcnt <= 0;
      msa  <= '0;
      msb  <= '0;
    end else if (mph != 1) begin
      if (start4) begin
        msa  <= tt_a4;
        msb  <= tt_b4;
        mcnt <= 0;
        mph  <= 1;
      end
    end else if (abort4) begin
      mph <= 0;
    end else if (mcnt + 1 == mlen(msa ^ msb)) begin
      mph <= 2;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  logic [15:0] cd;
  int          cl, cf;
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      cd = msa ^ msb;
      if (mph == 1) begin
        cf = fst(cd, mcnt);
        chk("m_vec", 32'(vec4), 32'(mcnt));
        chk("m_sa", 32'(s_a4), 32'(msa[mcnt]));
        chk("m_sb", 32'(s_b4), 32'(msb[mcnt]));
        chk("m_busy", 32'(busy4), 1);
        chk("m_done", 32'(done4), 0);
        chk("m_eq", 32'(eq4), 0);
        chk("m_mism", 32'(mism4), 32'(pc(cd, mcnt)));
        chk("m_fv", 32'(fv4), 32'(cf >= 0));
        if (cf >= 0) chk("m_fidx", 32'(fidx4), 32'(cf));
      end else if (mph == 2) begin
        cl = mlen(cd);
        cf = fst(cd, cl);
        chk("m_busy", 32'(busy4), 0);
        chk("m_done", 32'(done4), 1);
        chk("m_mism", 32'(mism4), 32'(pc(cd, cl)));
        chk("m_eq", 32'(eq4), 32'(pc(cd, cl) == 0));
        chk("m_fv", 32'(fv4), 32'(cf >= 0));
        if (cf >= 0) chk("m_fidx", 32'(fidx4), 32'(cf));
      end else begin
        chk("m_busy", 32'(busy4), 0);
        chk("m_done", 32'(done4), 0);
        chk("m_eq", 32'(eq4), 0);
        chk("m_mism", 32'(mism4), 0);
        chk("m_fv", 32'(fv4), 0);
      end
    end
  end

  // One sweep on the N=4 instance; poke>0 pulses start and flips tt_a mid-sweep.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input int poke,
                      input bit rel, output int n);
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    tt_a4 = a; tt_b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #2;
      if (done4) break;
      if (n == poke) begin
        start4 = 1'b1;
        tt_a4  = ~tt_a4;
      end else begin
        start4 = 1'b0;
      end
    end
    start4 = 1'b0;
    if (n >= 300) chk("run4_timeout", 32'(n), 0);
  endtask

  task automatic wait_vec4(input int t);
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (busy4 && vec4 == 4'(t)) break;
    end
    if (k >= 40) chk("wait_vec_timeout", 32'(k), 0);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    start4 = 0; abort4 = 0; tt_a4 = '0; tt_b4 = '0;
    start1 = 0; abort1 = 0; tt_a1 = '0; tt_b1 = '0;
    start8 = 0; abort8 = 0; tt_a8 = '0; tt_b8 = '0;
    #1;
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_vec", 32'(vec4), 0);
    chk("rst_mism", 32'(mism4), 0);
    chk("rst_fidx", 32'(fidx4), 0);
    chk("rst_fv", 32'(fv4), 0);
    chk("rst_eq", 32'(eq4), 0);

    // equal tables, start on the first edge after reset release
    run4(16'h5F00, 16'h5F00, 0, 1'b1, n);
    chk("t1_edges", 32'(n), 16);
    chk("t1_mism", 32'(mism4), 0);
    chk("t1_eq", 32'(eq4), 1);
    chk("t1_fv", 32'(fv4), 0);

    // single mismatch at minterm 0; mid-sweep start and tt_a change must be ignored
    run4(16'h5F00, 16'h5F01, 4, 1'b0, n);
    chk("t2_edges", 32'(n), STOP ? 1 : 16);
    chk("t2_mism", 32'(mism4), 1);
    chk("t2_fidx", 32'(fidx4), 0);
    chk("t2_fv", 32'(fv4), 1);
    chk("t2_eq", 32'(eq4), 0);

    // all minterms differ; restarted from DONE
    run4(16'h5F00, 16'hA0FF, 0, 1'b0, n);
    chk("t3_edges", 32'(n), STOP ? 1 : 16);
    chk("t3_mism", 32'(mism4), STOP ? 1 : 16);
    chk("t3_fidx", 32'(fidx4), 0);
    @(negedge clk); abort4 = 1'b1;
    @(negedge clk); abort4 = 1'b0;
    chk("t3_abort_done", 32'(done4), 1);
    chk("t3_abort_mism", 32'(mism4), STOP ? 1 : 16);

    // differ at bits 5 and 9: abort mid-sweep, then a clean rerun
    @(negedge clk);
    tt_a4 = 16'h1234; tt_b4 = 16'h1234 ^ 16'h0220; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    wait_vec4(STOP ? 3 : 7);
    @(negedge clk); abort4 = 1'b1;
    @(posedge clk); #2;
    chk("t4_ab_busy", 32'(busy4), 0);
    chk("t4_ab_done", 32'(done4), 0);
    chk("t4_ab_mism", 32'(mism4), 0);
    chk("t4_ab_fv", 32'(fv4), 0);
    chk("t4_ab_eq", 32'(eq4), 0);
    @(negedge clk); abort4 = 1'b0;
    run4(16'h1234, 16'h1234 ^ 16'h0220, 0, 1'b0, n);
    chk("t4_edges", 32'(n), STOP ? 6 : 16);
    chk("t4_mism", 32'(mism4), STOP ? 1 : 2);
    chk("t4_fidx", 32'(fidx4), 5);

    // asynchronous reset between edges at vec=10
    @(negedge clk);
    tt_a4 = 16'hA5C3; tt_b4 = 16'hA5C3 ^ 16'h0400; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    wait_vec4(10);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy4), 0);
    chk("t5_done", 32'(done4), 0);
    chk("t5_vec", 32'(vec4), 0);
    chk("t5_mism", 32'(mism4), 0);
    chk("t5_fidx", 32'(fidx4), 0);
    chk("t5_fv", 32'(fv4), 0);
    chk("t5_eq", 32'(eq4), 0);
    @(negedge clk); rst_n = 1'b1;
    run4(16'hA5C3, 16'hA5C3 ^ 16'h0400, 2, 1'b0, n);
    chk("t5_mism2", 32'(mism4), 1);
    chk("t5_fidx2", 32'(fidx4), 10);

    // N=1 boundary
    @(negedge clk); tt_a1 = 2'b10; tt_b1 = 2'b10; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n = 0;
    while (n < 20) begin @(posedge clk); n++; #2; if (done1) break; end
    chk("n1_edges", 32'(n), 2);
    chk("n1_eq", 32'(eq1), 1);
    chk("n1_mism", 32'(mism1), 0);

    // N=8 boundary: equal tables, then a single mismatch at the last minterm
    @(negedge clk); tt_a8 = {8{32'hDEADBEEF}}; tt_b8 = {8{32'hDEADBEEF}}; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    n = 0;
    while (n < 400) begin @(posedge clk); n++; #2; if (done8) break; end
    chk("n8_edges", 32'(n), 256);
    chk("n8_eq", 32'(eq8), 1);
    chk("n8_mism", 32'(mism8), 0);
    @(negedge clk); tt_b8[255] = ~tt_b8[255]; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    n = 0;
    while (n < 400) begin @(posedge clk); n++; #2; if (done8) break; end
    chk("n8b_edges", 32'(n), 256);
    chk("n8b_mism", 32'(mism8), 1);
    chk("n8b_fidx", 32'(fidx8), 255);
    chk("n8b_eq", 32'(eq8), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
